pipo_universal_shift_reg: RTL and testbench
===========================================

Name: pipo_universal_shift_reg

Overview:
- Parametrised successor to the 4-bit parallel-in/parallel-out register.
- Registers a WIDTH-bit word with selectable modes: hold, parallel load, shift left/right, rotate left/right.
- Adds a synchronous clear and a burst serialiser FSM that loads a word and streams it out on a serial pin with busy/done status.
- Sits between parallel datapath logic and serial links in the codebase.

Parameters:
- WIDTH, 8, register width in bits; legal values are 2 or more.
- MSB_FIRST, 1, burst serialisation order: 1 = MSB first (shift left), 0 = LSB first (shift right).
- CLEAR_VAL, '0, value loaded by reset and sync_clear (WIDTH bits).

Ports:
- clock  input  1  rising-edge clock.
- clear_n  input  1  asynchronous active-low reset.
- sync_clear  input  1  synchronous clear, active-high.
- mode  input  3  0=HOLD, 1=LOAD, 2=SHL, 3=SHR, 4=ROL, 5=ROR, 6/7=HOLD.
- data_in  input  WIDTH  parallel load data.
- ser_in_lsb  input  1  fill bit entering bit 0 on SHL.
- ser_in_msb  input  1  fill bit entering bit WIDTH-1 on SHR.
- start  input  1  burst request, accepted only in IDLE.
- out  output  WIDTH  register contents.
- ser_out  output  1  combinational: out[WIDTH-1] if MSB_FIRST, else out[0].
- busy  output  1  high while a burst is streaming.
- done  output  1  one-cycle pulse after the last burst bit.

Behaviour:
- Reset: clear_n low asynchronously forces out=CLEAR_VAL, state=IDLE, bit count=0, busy=0, done=0. Release is synchronous to the next edge.
- Priority at each rising edge, highest first:
  1. sync_clear
  2. burst in progress (SHIFT state)
  3. start in IDLE
  4. mode
- sync_clear=1: out<=CLEAR_VAL, state<=IDLE, bit count<=0, busy<=0, done<=0. This applies mid-burst too; the burst is aborted with no done pulse.
- IDLE with start=0, mode operations (single cycle, result visible after the edge):
  - LOAD: out<=data_in.
  - SHL: out<={out[WIDTH-2:0], ser_in_lsb}.
  - SHR: out<={ser_in_msb, out[WIDTH-1:1]}.
  - ROL: out<={out[WIDTH-2:0], out[WIDTH-1]}.
  - ROR: out<={out[0], out[WIDTH-1:1]}.
  - HOLD/6/7: out unchanged.
- IDLE with start=1: mode is ignored. out<=data_in, bit count<=0, busy<=1, state<=SHIFT.
- SHIFT, each edge:
  - If count==WIDTH-1: state<=IDLE, busy<=0, done<=1, out takes the final shift.
  - Otherwise: count<=count+1.
  - The shift direction follows MSB_FIRST, with the fill bit from ser_in_lsb (MSB first) or ser_in_msb (LSB first).
  - start and mode are ignored in SHIFT.
- Burst timing:
  - Bit k of the loaded word (in serial order) appears on ser_out during the k-th cycle after the load edge, k = 0..WIDTH-1.
  - busy is high for exactly WIDTH cycles.
  - done is high for the single cycle after busy falls.
  - A new start in that done cycle is accepted (back-to-back bursts, a 1-cycle gap at minimum).
- done is a registered 1-cycle pulse and is cleared on every other edge.
- Bit count width is $clog2(WIDTH); the counter never wraps because it stops at WIDTH-1.
- All outputs are registered except ser_out. No X propagates from unused mode codes.

Decomposition:
- Shared package pipo_pkg holds:
  - typedef enum logic [2:0] shift_mode_t {HOLD, LOAD, SHL, SHR, ROL, ROR}.
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
- One sub-module is natural: pipo_burst_ctrl, containing the FSM and bit counter, with outputs shift_en, load_en, busy and done. The datapath register stays in the top module.

Test Plan:
- Reset: drive clear_n=0 mid-cycle with out=8'hA5 -> out=8'h00 and busy=0 immediately, before any edge. Release, then LOAD 8'h3C -> out=8'h3C after one edge.
- Modes (WIDTH=4): LOAD 4'b1010, then SHL with ser_in_lsb=1 -> 4'b0101. Then ROR -> 4'b1010. Then SHR with ser_in_msb=0 -> 4'b0101. Then mode=7 -> unchanged.
- Burst MSB_FIRST (WIDTH=8): start with data_in=8'b1011_0010 -> ser_out reads 1,0,1,1,0,0,1,0 over 8 cycles, busy high for 8 cycles, then done high for 1 cycle.
- Burst LSB_FIRST (MSB_FIRST=0, WIDTH=4): data 4'b0011 -> ser_out reads 1,1,0,0. mode=LOAD asserted during the burst has no effect.
- Abort: assert sync_clear at the 3rd burst cycle -> out=0, busy=0 next edge, no done pulse. A following start is accepted normally.
- Back-to-back: start held high continuously -> second burst loads in the done cycle, with busy low for exactly 1 cycle between bursts.

Source files
------------

// File: rtl/pipo_universal_shift_reg_pkg.sv
// Shared mode and burst-state encodings for the universal shift register.
package pipo_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5
  } shift_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/pipo_universal_shift_reg_burst_ctrl.sv
// Burst serialiser control: IDLE/SHIFT FSM, bit counter, busy/done status.
module pipo_burst_ctrl
  import pipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic clear_n,
  input  logic sync_clear,
  input  logic start,
  output logic shift_en,
  output logic load_en,
  output logic busy,
  output logic done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          done_nxt;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    if (sync_clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt = SHIFT;
          count_nxt = '0;
        end
        SHIFT: if (count == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy     = (state == SHIFT);
  assign shift_en = (state == SHIFT) && !sync_clear;
  assign load_en  = (state == IDLE) && start && !sync_clear;

endmodule

// File: rtl/pipo_universal_shift_reg.sv
// WIDTH-bit universal shift register with a burst serialiser on ser_out.
module pipo_universal_shift_reg
  import pipo_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             sync_clear,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  logic             shift_en, load_en;
  logic [WIDTH-1:0] burst_shift;

  pipo_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clock      (clock),
    .clear_n    (clear_n),
    .sync_clear (sync_clear),
    .start      (start),
    .shift_en   (shift_en),
    .load_en    (load_en),
    .busy       (busy),
    .done       (done)
  );

  // Burst direction is fixed at elaboration; fill comes from the trailing side.
  assign burst_shift = MSB_FIRST ? {out[WIDTH-2:0], ser_in_lsb}
                                 : {ser_in_msb, out[WIDTH-1:1]};

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      out <= CLEAR_VAL;
    end else if (sync_clear) begin
      out <= CLEAR_VAL;
    end else if (shift_en) begin
      out <= burst_shift;
    end else if (load_en) begin
      out <= data_in;
    end else begin
      case (shift_mode_t'(mode))
        LOAD:    out <= data_in;
        SHL:     out <= {out[WIDTH-2:0], ser_in_lsb};
        SHR:     out <= {ser_in_msb, out[WIDTH-1:1]};
        ROL:     out <= {out[WIDTH-2:0], out[WIDTH-1]};
        ROR:     out <= {out[0], out[WIDTH-1:1]};
        default: out <= out;
      endcase
    end
  end

  assign ser_out = MSB_FIRST ? out[WIDTH-1] : out[0];

endmodule

// File: tb/tb_pipo_universal_shift_reg.sv
// Bench: 8-bit MSB-first and 4-bit LSB-first instances on shared stimulus.
module tb_pipo_universal_shift_reg;

  logic       clock = 1'b0;
  logic       clear_n, sync_clear, ser_in_lsb, ser_in_msb, start;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic [7:0] out8;
  logic [3:0] out4;
  logic       ser8, busy8, done8, ser4, busy4, done4;

  int checks = 0;
  int errors = 0;

  pipo_universal_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .mode(mode),
    .data_in(data_in), .ser_in_lsb(ser_in_lsb), .ser_in_msb(ser_in_msb),
    .start(start), .out(out8), .ser_out(ser8), .busy(busy8), .done(done8));

  pipo_universal_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .mode(mode),
    .data_in(data_in[3:0]), .ser_in_lsb(ser_in_lsb), .ser_in_msb(ser_in_msb),
    .start(start), .out(out4), .ser_out(ser4), .busy(busy4), .done(done4));

  always #5 clock = ~clock;

  // Reference model: index 0 = 8-bit MSB-first, index 1 = 4-bit LSB-first.
  // rem counts burst bits still to be shifted; 0 means idle.
  int m_w[2]    = '{8, 4};
  bit m_msbf[2] = '{1'b1, 1'b0};
  int m_out[2]  = '{0, 0};
  int m_rem[2]  = '{0, 0};
  bit m_done[2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_rem[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int w, mask, o;
      w = m_w[i]; mask = (1 << w) - 1; o = m_out[i];
      if (!clear_n || sync_clear) begin
        m_out[i] = 0; m_rem[i] = 0; m_done[i] = 1'b0;
      end else if (m_rem[i] > 0) begin
        if (m_msbf[i]) m_out[i] = ((o << 1) | int'(ser_in_lsb)) & mask;
        else           m_out[i] = (o >> 1) | (int'(ser_in_msb) << (w - 1));
        m_rem[i]--;
        m_done[i] = (m_rem[i] == 0);
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          m_out[i] = int'(data_in) & mask;
          m_rem[i] = w;
        end else begin
          case (int'(mode))
            1: m_out[i] = int'(data_in) & mask;
            2: m_out[i] = ((o << 1) | int'(ser_in_lsb)) & mask;
            3: m_out[i] = (o >> 1) | (int'(ser_in_msb) << (w - 1));
            4: m_out[i] = ((o << 1) | (o >> (w - 1))) & mask;
            5: m_out[i] = (o >> 1) | ((o & 1) << (w - 1));
            default: m_out[i] = o;
          endcase
        end
      end
    end
  endtask

  task automatic check_all();
    chk("model out8",  int'(out8),  m_out[0]);
    chk("model busy8", int'(busy8), int'(m_rem[0] > 0));
    chk("model done8", int'(done8), int'(m_done[0]));
    chk("model ser8",  int'(ser8),  (m_out[0] >> 7) & 1);
    chk("model out4",  int'(out4),  m_out[1]);
    chk("model busy4", int'(busy4), int'(m_rem[1] > 0));
    chk("model done4", int'(done4), int'(m_done[1]));
    chk("model ser4",  int'(ser4),  m_out[1] & 1);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
  task automatic async_rst();
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    chk("async out8", int'(out8), 0);
    chk("async busy8", int'(busy8), 0);
    chk("async out4", int'(out4), 0);
    chk("async busy4", int'(busy4), 0);
    #1 clear_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] mode;
    logic [7:0] data;
    logic       lsb;
    logic       msb;
    logic [3:0] exp4;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] pat;
  bit   busy_log[40];

  initial begin
    vecs[0] = '{3'd1, 8'h0A, 1'b0, 1'b0, 4'b1010};
    vecs[1] = '{3'd2, 8'h00, 1'b1, 1'b0, 4'b0101};
    vecs[2] = '{3'd5, 8'h00, 1'b0, 1'b0, 4'b1010};
    vecs[3] = '{3'd3, 8'h00, 1'b0, 1'b0, 4'b0101};
    vecs[4] = '{3'd7, 8'hFF, 1'b1, 1'b1, 4'b0101};

    clear_n = 1'b0; sync_clear = 1'b0; mode = 3'd0; data_in = '0;
    ser_in_lsb = 1'b0; ser_in_msb = 1'b0; start = 1'b0;
    #2;
    chk("reset out8", int'(out8), 0);
    chk("reset busy8", int'(busy8), 0);
    chk("reset done8", int'(done8), 0);
    chk("reset out4", int'(out4), 0);
    #10 clear_n = 1'b1;

    // Async reset with a live value, then LOAD after release.
    mode = 3'd1; data_in = 8'hA5; cyc();
    chk("preload out8", int'(out8), 8'hA5);
    mode = 3'd0;
    async_rst();
    mode = 3'd1; data_in = 8'h3C; cyc();
    chk("load after reset", int'(out8), 8'h3C);

    // Mode table, explicit expectations on the 4-bit instance.
    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode; data_in = vecs[i].data;
      ser_in_lsb = vecs[i].lsb; ser_in_msb = vecs[i].msb;
      cyc();
      chk($sformatf("mode vec %0d", i), int'(out4), int'(vecs[i].exp4));
    end
    mode = 3'd0; ser_in_lsb = 1'b0; ser_in_msb = 1'b0;

    // MSB-first burst on the 8-bit instance.
    pat = 8'b1011_0010;
    data_in = pat; start = 1'b1; cyc();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("msb burst bit %0d", k), int'(ser8), int'(pat[7-k]));
      chk($sformatf("msb burst busy %0d", k), int'(busy8), 1);
      cyc();
    end
    chk("msb burst done", int'(done8), 1);
    chk("msb burst busy end", int'(busy8), 0);
    cyc();
    chk("msb done pulse width", int'(done8), 0);

    // LSB-first burst on the 4-bit instance; LOAD during burst is ignored.
    pat = 8'h03;
    data_in = pat; start = 1'b1; cyc();
    start = 1'b0; mode = 3'd1; data_in = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lsb burst bit %0d", k), int'(ser4), int'(pat[k]));
      chk($sformatf("lsb burst busy %0d", k), int'(busy4), 1);
      cyc();
    end
    chk("lsb burst done", int'(done4), 1);
    mode = 3'd0; cyc();

    // Abort at the third burst cycle.
    data_in = 8'hFF; start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();
    sync_clear = 1'b1; cyc();
    chk("abort out8", int'(out8), 0);
    chk("abort busy8", int'(busy8), 0);
    sync_clear = 1'b0; cyc();
    chk("abort no done", int'(done8), 0);
    data_in = 8'h5A; start = 1'b1; cyc();
    chk("restart busy8", int'(busy8), 1);
    chk("restart out8", int'(out8), 8'h5A);
    start = 1'b0;
    repeat (10) cyc();

    // Back-to-back bursts with start held high.
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      data_in = 8'($urandom);
      cyc();
      busy_log[c] = busy8;
    end
    start = 1'b0;
    begin
      int fall, gap;
      fall = -1; gap = 0;
      for (int c = 1; c < 40; c++) begin
        if (fall < 0 && busy_log[c-1] && !busy_log[c]) fall = c;
        else if (fall >= 0 && gap == 0 && busy_log[c]) gap = c - fall;
      end
      chk("b2b gap cycles", gap, 1);
    end
    repeat (10) cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      mode = 3'($urandom_range(0, 7));
      data_in = 8'($urandom);
      ser_in_lsb = 1'($urandom); ser_in_msb = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      sync_clear = ($urandom_range(0, 15) == 0);
      cyc();
      if ($urandom_range(0, 49) == 0) async_rst();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
